// File: rtl/alu_ctrl_seq.sv
// Registered MIPS ALU control decoder with iterative mult/div sequencing and valid/ready handshake.
// Optional synchronous flush port is enabled by defining ALU_CTRL_FLUSH_EN.
module alu_ctrl_seq #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef ALU_CTRL_FLUSH_EN
  input  logic       flush,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] funct,
  input  logic [2:0] unitControl,
  output logic       out_valid,
  output logic [2:0] aluSel,
  output logic       mdStart,
  output logic       mdOp,
  output logic       mdBusy,
  output logic       illegal
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // Returns {multi_cycle, is_div, illegal, sel[2:0]}
  function automatic logic [5:0] decode(input logic [2:0] uc, input logic [5:0] fn);
    logic [5:0] r;
    r = {3'b001, 3'b100};
    case (uc)
      3'b000: begin
        case (fn)
          6'b100000: r = {3'b000, 3'b010};
          6'b100010: r = {3'b000, 3'b110};
          6'b101010: r = {3'b000, 3'b111};
          6'b100100: r = {3'b000, 3'b000};
          6'b100101: r = {3'b000, 3'b001};
          6'b000000: r = {3'b000, 3'b100};
          6'b011000: r = {3'b100, 3'b011};
          6'b011010: r = {3'b110, 3'b101};
          default:   r = {3'b001, 3'b100};
        endcase
      end
      3'b010:  r = {3'b000, 3'b010};
      3'b001:  r = {3'b000, 3'b001};
      3'b011:  r = {3'b000, 3'b000};
      3'b111:  r = {3'b000, 3'b111};
      3'b110:  r = {3'b000, 3'b110};
      default: r = {3'b001, 3'b100};
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic             md_start_q, md_start_d;
  logic             md_op_q, md_op_d;
  logic             md_busy_q, md_busy_d;
  logic             illegal_q, illegal_d;

  logic             flush_s;
  logic [5:0]       dec_s;
  logic             accept_s;
  logic [CNT_W-1:0] lat_load_s;
  logic             long_op_s;
  logic             done_s;

`ifdef ALU_CTRL_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign dec_s      = decode(unitControl, funct);
  assign accept_s   = in_valid && (state_q == S_IDLE) && !flush_s;
  assign lat_load_s = dec_s[4] ? DIV_LOAD : MUL_LOAD;
  // A latency of one has no BUSY phase and completes like a single-cycle op
  assign long_op_s  = dec_s[5] && (lat_load_s != {CNT_W{1'b0}});
  assign done_s     = (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      alu_sel_q   <= 3'b100;
      md_start_q  <= 1'b0;
      md_op_q     <= 1'b0;
      md_busy_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      alu_sel_q   <= alu_sel_d;
      md_start_q  <= md_start_d;
      md_op_q     <= md_op_d;
      md_busy_q   <= md_busy_d;
      illegal_q   <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_s) begin
      state_d = S_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s && long_op_s) begin
            state_d = S_BUSY;
            cnt_d   = lat_load_s;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          // Completion happens on the edge that would take the counter to zero
          if (done_s) begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  always_comb begin
    out_valid_d = 1'b0;
    md_start_d  = 1'b0;
    md_busy_d   = 1'b0;
    alu_sel_d   = alu_sel_q;
    illegal_d   = illegal_q;
    md_op_d     = md_op_q;
    if (flush_s) begin
      md_busy_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            md_start_d = dec_s[5];
            if (dec_s[5]) begin
              md_op_d = dec_s[4];
            end else begin
              md_op_d = md_op_q;
            end
            if (long_op_s) begin
              md_busy_d = 1'b1;
            end else begin
              out_valid_d = 1'b1;
              alu_sel_d   = dec_s[2:0];
              illegal_d   = dec_s[3];
            end
          end else begin
            out_valid_d = 1'b0;
          end
        end
        S_BUSY: begin
          if (done_s) begin
            out_valid_d = 1'b1;
            alu_sel_d   = md_op_q ? 3'b101 : 3'b011;
            illegal_d   = 1'b0;
          end else begin
            md_busy_d   = 1'b1;
          end
        end
        default: begin
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign aluSel    = alu_sel_q;
  assign mdStart   = md_start_q;
  assign mdOp      = md_op_q;
  assign mdBusy    = md_busy_q;
  assign illegal   = illegal_q;

endmodule
